// File: rtl/debounce_tick_amisha.sv
// debounce_tick_amisha
// Switch debouncer: two-flop synchronizer, counter-based filter FSM, and a
// registered debounced level with a one-cycle rising-edge tick.
// Optional build macro DB_FALL_TICK_EN: when defined, db_fall_tick_amisha
// pulses for one cycle on the debounced 1->0 transition; otherwise it is
// tied to 0.
//
// state | meaning
// ------+---------------------------------------------------------------
// ZERO  | stable low, waiting for a synchronized 1
// WAIT1 | low, counting down; any 0 aborts back to ZERO
// ONE   | stable high, waiting for a synchronized 0
// WAIT0 | high, counting down; any 1 aborts back to ONE
module debounce_tick_amisha #(
  parameter int N = 19
) (
  input  logic clk_amisha,
  input  logic reset_amisha,
  input  logic sw_amisha,
  output logic db_level_amisha,
  output logic db_tick_amisha,
  output logic db_fall_tick_amisha
);

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } state_t;

  // Full interval reload; all ones so the down-count never wraps.
  localparam logic [N-1:0] CNT_LOAD = '1;
  localparam logic [N-1:0] CNT_DEC  = N'(1);

  logic         s1;
  logic         sw_s;
  state_t       state;
  state_t       state_next;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_next;
  logic         level_next;
  logic         tick_next;
`ifdef DB_FALL_TICK_EN
  logic         fall_next;
  logic         fall_q;
`endif

  // Bring the raw switch level into the clock domain.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      s1   <= 1'b0;
      sw_s <= 1'b0;
    end else begin
      s1   <= sw_amisha;
      sw_s <= s1;
    end
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      state           <= ZERO;
      cnt             <= '0;
      db_level_amisha <= 1'b0;
      db_tick_amisha  <= 1'b0;
    end else begin
      state           <= state_next;
      cnt             <= cnt_next;
      db_level_amisha <= level_next;
      db_tick_amisha  <= tick_next;
    end
  end

  // Next-state, timer and tick decode; a terminal count of zero commits.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tick_next  = 1'b0;
`ifdef DB_FALL_TICK_EN
    fall_next  = 1'b0;
`endif
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_next = WAIT1;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_next = ZERO;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_DEC;
        end else begin
          state_next = ONE;
          tick_next  = 1'b1;
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_next = WAIT0;
          cnt_next   = CNT_LOAD;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_next = ONE;
        end else if (cnt != '0) begin
          cnt_next = cnt - CNT_DEC;
        end else begin
          state_next = ZERO;
`ifdef DB_FALL_TICK_EN
          fall_next  = 1'b1;
`endif
        end
      end
      default: begin
        state_next = ZERO;
      end
    endcase
    level_next = (state_next == ONE) || (state_next == WAIT0);
  end

`ifdef DB_FALL_TICK_EN
  // Falling tick register, mirrors the rising tick timing.
  always_ff @(posedge clk_amisha) begin
    if (reset_amisha) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_next;
    end
  end

  assign db_fall_tick_amisha = fall_q;
`else
  assign db_fall_tick_amisha = 1'b0;
`endif

endmodule
